bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 95 +++++++++
 tb/tb_bounce_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: corrupts a clean level with pseudo-random toggles for a bounded
// window after each accepted change, mimicking a mechanical contact. Used to
// exercise debouncers. A Galois LFSR supplies the toggle pattern, so identical
// seed and stimulus always produce the same dout sequence.
module bounce_gen #(
  parameter int          BOUNCE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       enable,
  output logic       dout,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  localparam int          CW     = $clog2(BOUNCE_CYCLES + 1);
  // An all-zero Galois LFSR locks up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [CW-1:0] RELOAD = CW'(BOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t        state;
  logic          din_q;
  logic          level;   // last settled value
  logic          target;  // value the current window settles to
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;

  // Next LFSR state: shift right, fold taps in when the outgoing bit is 1.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  end

  // Input register, LFSR and the IDLE/BOUNCE machine with registered outputs.
  // Priority inside BOUNCE: disable > retrigger > countdown > settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      din_q      <= 1'b0;
      level      <= 1'b0;
      target     <= 1'b0;
      cnt        <= '0;
      lfsr       <= SEED;
      dout       <= 1'b0;
      busy       <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      din_q <= din;
      lfsr  <= lfsr_nxt;
      unique case (state)
        IDLE: begin
          if (!enable) begin
            level <= din_q;
            dout  <= din_q;
          end else if (din_q != level) begin
            state  <= BOUNCE;
            busy   <= 1'b1;
            target <= din_q;
            dout   <= din_q;
            cnt    <= RELOAD;
            if (bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
          end
        end
        BOUNCE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            dout  <= target;
            level <= target;
          end else if (din_q != target) begin
            target <= din_q;
            dout   <= din_q;
            cnt    <= RELOAD;
            if (bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
          end else if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            dout <= dout ^ lfsr[0];
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            dout  <= target;
            level <= target;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen. A main instance (8-cycle window, default
// seed) is checked edge by edge against a scoreboard whose toggle bits come
// from an independent LFSR model; side instances cover the one-cycle window
// and the zero-seed substitution.
module tb_bounce_gen;

  logic       clk;
  logic       rst;
  logic       din;
  logic       enable;
  logic       dout,   busy;
  logic [7:0] bcnt;
  logic       dout_1, busy_1;
  logic [7:0] bcnt_1;
  logic       dout_z, busy_z;
  logic [7:0] bcnt_z;
  logic       dout_o, busy_o;
  logic [7:0] bcnt_o;

  typedef struct packed {
    logic       d;
    logic       b;
    logic [7:0] c;
  } exp_t;

  exp_t       sb[$];
  logic       pq[$];
  logic       trace[$];
  logic [15:0] m_lfsr;
  int         errors;
  int         checks;
  int         exp_bc;

  bounce_gen #(.BOUNCE_CYCLES(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .dout(dout), .busy(busy), .bounce_cnt(bcnt));

  bounce_gen #(.BOUNCE_CYCLES(1), .LFSR_SEED(16'h0001)) dut_1 (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .dout(dout_1), .busy(busy_1), .bounce_cnt(bcnt_1));

  bounce_gen #(.BOUNCE_CYCLES(8), .LFSR_SEED(16'h0000)) dut_z (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .dout(dout_z), .busy(busy_z), .bounce_cnt(bcnt_z));

  bounce_gen #(.BOUNCE_CYCLES(8), .LFSR_SEED(16'h0001)) dut_o (
    .clk(clk), .rst(rst), .din(din), .enable(enable),
    .dout(dout_o), .busy(busy_o), .bounce_cnt(bcnt_o));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR for the main instance: x^16+x^14+x^13+x^11+1, Galois.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b0; enable = 1'b0;
    tick(); tick();
    checks++;
    if (dout !== 1'b0 || busy !== 1'b0 || bcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset main: got dout=%b busy=%b cnt=%0d want 0/0/0", dout, busy, bcnt);
    end
    checks++;
    if ({dout_1, busy_1, dout_z, busy_z, dout_o, busy_o} !== 6'b0 || bcnt_1 !== 8'd0 || bcnt_z !== 8'd0) begin
      errors++;
      $display("FAIL reset side: got %b%b%b%b%b%b cnt1=%0d cntz=%0d want all 0",
               dout_1, busy_1, dout_z, busy_z, dout_o, busy_o, bcnt_1, bcnt_z);
    end
    rst = 1'b0; enable = 1'b1;
    tick(); tick();
    checks++;
    if (dout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got dout=%b busy=%b want 0/0", dout, busy);
    end
    exp_bc = 0;
  endtask

  // din 0->1; window of 8 cycles, toggles on edges 3..9, settled from edge 10.
  task automatic test_bounce();
    exp_t e;
    logic ed;
    ed  = 1'b0;
    din = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 2) begin ed = 1'b1; exp_bc++; end
      else if (k >= 3 && k <= 9) ed = ed ^ m_lfsr[0];
      else if (k >= 10) ed = 1'b1;
      e.d = ed; e.b = (k >= 2 && k <= 9); e.c = 8'(exp_bc);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || busy !== e.b || bcnt !== e.c) begin
        errors++;
        $display("FAIL bounce edge%0d: got dout=%b busy=%b cnt=%0d want %b/%b/%0d",
                 k, dout, busy, bcnt, e.d, e.b, e.c);
      end
      if (k >= 2) begin
        checks++;
        if (dout_1 !== 1'b1 || busy_1 !== (k == 2)) begin
          errors++;
          $display("FAIL one_cycle_window edge%0d: got dout=%b busy=%b want 1/%b",
                   k, dout_1, busy_1, (k == 2));
        end
      end
    end
  endtask

  // enable=0: dout follows din two edges later, no window ever opens.
  task automatic test_passthrough();
    logic want;
    enable = 1'b0;
    pq.push_back(1'b1);
    for (int k = 0; k < 22; k++) begin
      din = ((k / 5) % 2 == 0) && (k < 15);
      pq.push_back(din);
      tick();
      want = pq.pop_front();
      checks++;
      if (dout !== want || busy !== 1'b0 || bcnt !== 8'(exp_bc)) begin
        errors++;
        $display("FAIL passthrough k=%0d: got dout=%b busy=%b cnt=%0d want %b/0/%0d",
                 k, dout, busy, bcnt, want, exp_bc);
      end
    end
    pq.delete();
  endtask

  // din 0->1, then 1->0 four cycles later: window restarts, settles to 0 at edge 14.
  task automatic test_retrigger();
    exp_t e;
    logic ed;
    ed = 1'b0;
    enable = 1'b1;
    din = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) din = 1'b0;
      if (k == 2) begin ed = 1'b1; exp_bc++; end
      else if (k == 6) begin ed = 1'b0; exp_bc++; end
      else if ((k >= 3 && k <= 5) || (k >= 7 && k <= 13)) ed = ed ^ m_lfsr[0];
      else if (k >= 14) ed = 1'b0;
      e.d = ed; e.b = (k >= 2 && k <= 13); e.c = 8'(exp_bc);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || busy !== e.b || bcnt !== e.c) begin
        errors++;
        $display("FAIL retrigger edge%0d: got dout=%b busy=%b cnt=%0d want %b/%b/%0d",
                 k, dout, busy, bcnt, e.d, e.b, e.c);
      end
    end
  endtask

  // enable drops mid-window: next edge forces target, later changes pass through.
  task automatic test_disable();
    exp_t e;
    logic ed;
    ed = 1'b0;
    din = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) enable = 1'b0;
      if (k == 7) din = 1'b0;
      if (k == 2) begin ed = 1'b1; exp_bc++; end
      else if (k == 3 || k == 4) ed = ed ^ m_lfsr[0];
      else if (k >= 5 && k <= 7) ed = 1'b1;
      else if (k >= 8) ed = 1'b0;
      e.d = ed; e.b = (k >= 2 && k <= 4); e.c = 8'(exp_bc);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || busy !== e.b || bcnt !== e.c) begin
        errors++;
        $display("FAIL disable edge%0d: got dout=%b busy=%b cnt=%0d want %b/%b/%0d",
                 k, dout, busy, bcnt, e.d, e.b, e.c);
      end
    end
  endtask

  // One-cycle reset in the middle of a window; new window 2 edges after release.
  task automatic test_reset_mid();
    exp_t e;
    logic ed;
    ed = 1'b0;
    enable = 1'b1;
    din = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) rst = 1'b1;
      if (k == 5) rst = 1'b0;
      if (k == 2) begin ed = 1'b1; exp_bc++; end
      else if (k == 3) ed = ed ^ m_lfsr[0];
      else if (k == 4) begin ed = 1'b0; exp_bc = 0; end
      else if (k == 5) ed = 1'b0;
      else if (k == 6) begin ed = 1'b1; exp_bc++; end
      else if (k >= 7 && k <= 13) ed = ed ^ m_lfsr[0];
      else if (k >= 14) ed = 1'b1;
      e.d = ed; e.b = (k == 2 || k == 3 || (k >= 6 && k <= 13)); e.c = 8'(exp_bc);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || busy !== e.b || bcnt !== e.c) begin
        errors++;
        $display("FAIL reset_mid edge%0d: got dout=%b busy=%b cnt=%0d want %b/%b/%0d",
                 k, dout, busy, bcnt, e.d, e.b, e.c);
      end
      if (k == 4) begin
        checks++;
        if (bcnt_1 !== 8'd0 || busy_1 !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid side: got cnt1=%0d busy1=%b want 0/0", bcnt_1, busy_1);
        end
      end
    end
  endtask

  // 300 accepted toggles: counter saturates, each window settles in time,
  // and seed 0 tracks seed 1 cycle for cycle.
  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      din = ~din;
      exp_bc++;
      e.d = din; e.b = 1'b0; e.c = 8'(exp_bc > 255 ? 255 : exp_bc);
      sb.push_back(e);
      for (int t = 0; t < 12; t++) begin
        tick();
        checks++;
        if (dout_z !== dout_o || busy_z !== busy_o) begin
          errors++;
          $display("FAIL seed_zero toggle%0d t%0d: got dout=%b busy=%b want %b/%b",
                   i, t, dout_z, busy_z, dout_o, busy_o);
        end
      end
      e = sb.pop_front();
      checks++;
      if (dout !== e.d || busy !== e.b || bcnt !== e.c) begin
        errors++;
        $display("FAIL saturate toggle%0d: got dout=%b busy=%b cnt=%0d want %b/%b/%0d",
                 i, dout, busy, bcnt, e.d, e.b, e.c);
      end
    end
    checks++;
    if (bcnt !== 8'd255 || bcnt_1 !== 8'd255 || bcnt_z !== 8'd255) begin
      errors++;
      $display("FAIL saturate_final: got %0d/%0d/%0d want 255/255/255", bcnt, bcnt_1, bcnt_z);
    end
  endtask

  // Same seed and stimulus twice from reset: dout traces must match exactly.
  task automatic test_repeat();
    int gaps[8];
    int idx;
    gaps = '{3, 6, 4, 12, 2, 5, 11, 7};
    for (int run = 0; run < 2; run++) begin
      rst = 1'b1; din = 1'b0; enable = 1'b1;
      tick(); tick();
      rst = 1'b0;
      idx = 0;
      for (int g = 0; g < 8; g++) begin
        din = ~din;
        for (int t = 0; t < gaps[g]; t++) begin
          tick();
          if (run == 0) trace.push_back(dout);
          else begin
            checks++;
            if (dout !== trace[idx]) begin
              errors++;
              $display("FAIL repeat cycle%0d: got dout=%b want %b", idx, dout, trace[idx]);
            end
            idx++;
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_bc = 0;
    test_reset();
    test_bounce();
    test_passthrough();
    test_retrigger();
    test_disable();
    test_reset_mid();
    test_saturate();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
